// File: rtl/dpm_fifo_ctrl_if.sv
// Controller/peripheral connection for a dual-port memory with a one-cycle
// registered read port.
interface DualPortMem_If #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 10
) ();
    logic                 clk;
    logic                 w_enable;
    logic [AddrWidth-1:0] w_addr;
    logic [DataWidth-1:0] w_data;
    logic [AddrWidth-1:0] r_addr;
    logic [DataWidth-1:0] r_data;

    modport ctrl (
        output clk, w_enable, w_addr, w_data, r_addr,
        input  r_data
    );

    modport prph (
        input  clk, w_enable, w_addr, w_data, r_addr,
        output r_data
    );
endinterface

// File: rtl/dpm_fifo_ctrl.sv
// Synchronous valid/ready FIFO built on a dual-port memory; a 2-entry output
// stage hides the registered read latency so a ready consumer gets one word per clock.
module dpm_fifo_ctrl #(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned AddrWidth  = 10,
    parameter int unsigned Depth      = 1024,
    parameter int unsigned BottomAddr = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DataWidth-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DataWidth-1:0] out_data,
    output logic [AddrWidth+1:0] level,
    DualPortMem_If.ctrl          dpm_if
);
    localparam logic [AddrWidth-1:0] FirstAddr = AddrWidth'(BottomAddr);
    localparam logic [AddrWidth-1:0] LastAddr  = AddrWidth'(BottomAddr + Depth - 1);
    localparam logic [AddrWidth:0]   DepthCnt  = (AddrWidth+1)'(Depth);

    logic [AddrWidth-1:0] wr_ptr;
    logic [AddrWidth-1:0] rd_ptr;
    logic [AddrWidth:0]   mem_count;
    logic                 inflight;
    logic [1:0]           occ;
    logic [1:0]           occ_n;
    logic [DataWidth-1:0] head;
    logic [DataWidth-1:0] head_n;
    logic [DataWidth-1:0] tail;
    logic [DataWidth-1:0] tail_n;
    logic [AddrWidth+1:0] level_q;
    logic                 push;
    logic                 pop;
    logic                 fetch;
    logic [1:0]           slots_used;

    assign in_ready   = !rst && (mem_count < DepthCnt);
    assign push       = in_valid && in_ready;
    assign out_valid  = (occ != 2'd0);
    assign pop        = out_valid && out_ready;
    assign out_data   = head;
    assign level      = level_q;

    // A read already in flight reserves a stage slot; a pop this cycle frees one.
    assign slots_used = occ + {1'b0, inflight};
    assign fetch      = (mem_count != '0) && ((slots_used < 2'd2) || pop);

    assign dpm_if.clk      = clk;
    assign dpm_if.w_enable = push;
    assign dpm_if.w_addr   = wr_ptr;
    assign dpm_if.w_data   = in_data;
    assign dpm_if.r_addr   = rd_ptr;

    // Shift on pop first, then land the returning read in the first free entry.
    always_comb begin
        head_n = head;
        tail_n = tail;
        occ_n  = occ;
        if (pop) begin
            head_n = tail;
            occ_n  = occ - 2'd1;
        end
        if (inflight) begin
            if (occ_n == 2'd0) begin
                head_n = dpm_if.r_data;
            end else begin
                tail_n = dpm_if.r_data;
            end
            occ_n = occ_n + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= FirstAddr;
            rd_ptr    <= FirstAddr;
            mem_count <= '0;
            inflight  <= 1'b0;
            occ       <= '0;
            head      <= '0;
            tail      <= '0;
            level_q   <= '0;
        end else begin
            occ      <= occ_n;
            head     <= head_n;
            tail     <= tail_n;
            inflight <= fetch;

            if (push) begin
                wr_ptr <= (wr_ptr == LastAddr) ? FirstAddr : wr_ptr + 1'b1;
            end
            if (fetch) begin
                rd_ptr <= (rd_ptr == LastAddr) ? FirstAddr : rd_ptr + 1'b1;
            end

            if (push && !fetch) begin
                mem_count <= mem_count + 1'b1;
            end else if (fetch && !push) begin
                mem_count <= mem_count - 1'b1;
            end

            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end
endmodule

// File: doc/dpm_fifo_ctrl.md
# dpm_fifo_ctrl

- Synchronous FIFO controller that owns the controller (`ctrl`) side of `DualPortMem_If` and drives a `DualPortMemPrph` as its storage.
- Upstream producer and downstream consumer each see a valid/ready stream.
- The block hides the memory's one-cycle registered read latency behind a 2-entry output stage, so a continuously ready consumer receives one word per clock.
- Intended as the standard buffering element between pipeline stages that already use dual-port memories.

## Interface

Parameters:
- `DataWidth`, 32, word width; must equal `dpm_if.DataWidth`.
- `AddrWidth`, 10, address width; must equal `dpm_if.AddrWidth`.
- `Depth`, 1024, memory cells used; 1 ≤ Depth ≤ 2^AddrWidth; must match the attached peripheral.
- `BottomAddr`, 0, lowest memory address used; must match the attached peripheral.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  input  1  clock; also forwarded to `dpm_if.clk`.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  producer offers `in_data`.
- `in_ready`  output  1  FIFO accepts; a transfer occurs when `in_valid & in_ready`.
- `in_data`  input  DataWidth  write word.
- `out_valid`  output  1  `out_data` holds the oldest word.
- `out_ready`  input  1  consumer takes the word; a transfer occurs when `out_valid & out_ready`.
- `out_data`  output  DataWidth  head word; held stable while `out_valid & !out_ready`.
- `level`  output  AddrWidth+2  total words held (memory + in-flight + output stage).
- `dpm_if`  modport `ctrl`  —  drives `clk`, `w_enable`, `w_addr`, `w_data`, `r_addr`; samples `r_data`.

## Operation

- State:
  - `wr_ptr`, `rd_ptr`: range BottomAddr..BottomAddr+Depth-1.
  - `mem_count`: 0..Depth.
  - `inflight`: 1 bit; a read was issued last cycle.
  - Output stage: 2 entries, `occ` 0..2, head/tail registers.
- Write path:
  - `in_ready = !rst & (mem_count < Depth)`.
  - `w_enable = in_valid & in_ready`; `w_addr = wr_ptr`; `w_data = in_data`.
  - `wr_ptr` advances on each write.
- Fetch:
  - Issue when `mem_count > 0` and `occ + inflight < 2`, counting a pop in the same cycle as freeing a slot.
  - `r_addr = rd_ptr` at all times; `rd_ptr` advances on each fetch; `inflight` is set for the next cycle.
- Capture: when `inflight == 1`, `dpm_if.r_data` is written into the output stage at the next edge.
- Pop: `out_data` is the head entry; on a pop, the second entry shifts to head.
- `mem_count` update:
  - Write only: +1. Fetch only: −1. Both: unchanged.
  - A word written this cycle is not fetchable until the next cycle. The memory returns old data on a same-address read/write, so this rule is mandatory.
- Pointer wrap: BottomAddr+Depth-1 → BottomAddr. Depth need not be a power of two.
- `level` update:
  - +1 per accepted push, −1 per pop, unchanged when both occur in the same cycle.
  - Maximum value is Depth+2.
- Full: `in_ready = 0` when `mem_count == Depth`, even if the output stage has room.
- Empty: `out_valid = 0` whenever `occ == 0`. A pop attempted while empty is ignored.
- Reset, asserted at any time:
  - Pointers = BottomAddr; counts, `occ` and `inflight` cleared.
  - An in-flight read result is discarded.
  - Memory contents are not cleared.

## Timing

- Reset values:
  - `in_ready` = 0 while `rst` is high.
  - `out_valid` = 0, `out_data` = 0, `level` = 0.
  - `w_enable` = 0; `w_addr` and `r_addr` = BottomAddr.
- Push-to-out latency: for a word accepted in cycle N into an empty FIFO:
  - fetch in N+1;
  - `r_data` valid in N+2;
  - `out_valid` = 1 in N+3.
- Throughput: with `out_ready` held at 1, one word per cycle sustained in steady state.
- `in_ready` and `level` reflect registered state only, with no combinational path from `out_ready` to `in_ready`.
- `out_valid` and `out_data` come straight from registers.
- `dpm_if.clk` is tied to `clk` with no gating.

## Test plan

- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles with `out_ready` = 1 → `out_valid` rises 3 cycles after the first push; 0x11, 0x22, 0x33 appear on consecutive cycles; `level` returns to 0.
- Depth=4, `out_ready` = 0, push 8 words → 6 accepted (4 in memory + 2 in output stage); `in_ready` = 0; `level` = 6; draining returns words in push order.
- Depth=5, BottomAddr=3, stream 20 words with random `out_ready` → `w_addr` and `r_addr` wrap 7→3; no loss, no duplication, order preserved.
- Near-full, push and pop in the same cycle → `level` unchanged; `in_ready` remains 1 while `mem_count < Depth`.
- With a read in flight, pulse `rst` for one cycle → `out_valid` = 0 and `level` = 0 immediately; the next pushed word 0xAB is the first output.
- Push while empty and pop attempt in the same cycle → the pop is ignored and 0xAB is delivered 3 cycles later.
